// File: rtl/finder_row_scanner.sv
// Walks one cleaned row a pixel per clock, run-length encodes it and flags
// dark:light:dark:light:dark run groups matching the 1:1:3:1:1 finder ratio.
module finder_row_scanner #(
  parameter int WIDTH = 480
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic             pattern_valid,
  output logic             busy,
  output logic             hit_valid,
  output logic [8:0]       hit_center,
  output logic [8:0]       hit_width,
  output logic             scan_done,
  output logic [3:0]       hit_count
);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

  state_t           state;
  logic [WIDTH-1:0] row;
  logic [8:0]       index;
  logic [8:0]       run_len;
  logic             run_color;
  logic [8:0]       hist_len [4];
  logic [2:0]       hist_cnt;

  logic             pixel;
  logic             push_now;
  logic [8:0]       e_pos;
  logic [11:0]      t_sum;
  logic signed [15:0] t_s;
  logic             ratio_hit;
  logic             eval_hit;
  logic [8:0]       center_calc;

  // Distance of one run from its ideal share of the group, scaled to avoid division.
  function automatic logic ratio_ok(input logic signed [15:0] ref_t, input logic [8:0] len);
    logic signed [15:0] diff;
    diff = ref_t - 16'sd7 * signed'({7'd0, len});
    if (diff < 0) diff = -diff;
    return (diff <<< 1) < ref_t;
  endfunction

  assign pixel = row[index];

  // The run being closed is n0; the four retained runs become n1..n4.
  always_comb begin
    push_now    = 1'b0;
    e_pos       = index;
    t_sum       = 12'd0;
    t_s         = 16'sd0;
    ratio_hit   = 1'b0;
    eval_hit    = 1'b0;
    center_calc = 9'd0;
    if (state == FLUSH) begin
      push_now = 1'b1;
      e_pos    = 9'(WIDTH);
    end else if (state == SCAN && index != 9'd0 && pixel != run_color) begin
      push_now = 1'b1;
    end
    t_sum = {3'd0, run_len} + {3'd0, hist_len[0]} + {3'd0, hist_len[1]}
          + {3'd0, hist_len[2]} + {3'd0, hist_len[3]};
    t_s = signed'({4'd0, t_sum});
    ratio_hit = (t_sum >= 12'd7)
              && ratio_ok(t_s, run_len)
              && ratio_ok(t_s, hist_len[0])
              && ratio_ok(t_s * 16'sd3, hist_len[1])
              && ratio_ok(t_s, hist_len[2])
              && ratio_ok(t_s, hist_len[3]);
    eval_hit = push_now && (hist_cnt == 3'd4) && !run_color && ratio_hit;
    center_calc = e_pos - run_len - hist_len[0] - hist_len[1] + (hist_len[1] >> 1);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      row        <= '0;
      index      <= 9'd0;
      run_len    <= 9'd0;
      run_color  <= 1'b0;
      hist_cnt   <= 3'd0;
      for (int i = 0; i < 4; i++) hist_len[i] <= 9'd0;
      busy       <= 1'b0;
      hit_valid  <= 1'b0;
      hit_center <= 9'd0;
      hit_width  <= 9'd0;
      scan_done  <= 1'b0;
      hit_count  <= 4'd0;
    end else begin
      hit_valid <= 1'b0;
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pattern_valid) begin
            row       <= pattern_in;
            index     <= 9'd0;
            hit_count <= 4'd0;
            hist_cnt  <= 3'd0;
            busy      <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (index == 9'd0 || pixel != run_color) begin
            run_color <= pixel;
            run_len   <= 9'd1;
          end else begin
            run_len <= run_len + 9'd1;
          end
          if (index == 9'(WIDTH - 1)) state <= FLUSH;
          else index <= index + 9'd1;
        end
        FLUSH: begin
          scan_done <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (push_now) begin
        hist_len[0] <= run_len;
        hist_len[1] <= hist_len[0];
        hist_len[2] <= hist_len[1];
        hist_len[3] <= hist_len[2];
        if (hist_cnt != 3'd4) hist_cnt <= hist_cnt + 3'd1;
      end

      if (eval_hit) begin
        hit_valid  <= 1'b1;
        hit_center <= center_calc;
        hit_width  <= t_sum[8:0];
        if (hit_count != 4'd15) hit_count <= hit_count + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_finder_row_scanner.sv
// Self-checking bench: directed finder rows plus random rows, checked cycle by
// cycle against a run-list reference model.
module tb_finder_row_scanner;

  localparam int WIDTH = 480;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic [WIDTH-1:0] pattern_in;
  logic             pattern_valid;
  logic             busy, hit_valid, scan_done;
  logic [8:0]       hit_center, hit_width;
  logic [3:0]       hit_count;

  finder_row_scanner #(.WIDTH(WIDTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .pattern_in(pattern_in),
    .pattern_valid(pattern_valid), .busy(busy), .hit_valid(hit_valid),
    .hit_center(hit_center), .hit_width(hit_width), .scan_done(scan_done),
    .hit_count(hit_count)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int exp_hit [WIDTH+2];
  int exp_c   [WIDTH+2];
  int exp_w   [WIDTH+2];
  int last_center = 0;
  int last_width  = 0;
  int seen_hits;
  int busy_cycles;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: split the row into runs, then test every 5-run window ending dark.
  task automatic buildModel(input logic [WIDTH-1:0] p);
    int rs[$], rl[$], rc[$];
    int t, e, j2;
    bit ok;
    for (int c = 0; c < WIDTH + 2; c++) begin exp_hit[c] = 0; exp_c[c] = 0; exp_w[c] = 0; end
    for (int k = 0; k < WIDTH; k++) begin
      if (k == 0 || int'(p[k]) != rc[$]) begin
        rs.push_back(k); rl.push_back(1); rc.push_back(int'(p[k]));
      end else begin
        rl[rl.size()-1] = rl[rl.size()-1] + 1;
      end
    end
    for (int j = 4; j < rs.size(); j++) begin
      if (rc[j] != 0) continue;
      t = rl[j] + rl[j-1] + rl[j-2] + rl[j-3] + rl[j-4];
      ok = (t >= 7);
      foreach (rl[i]) begin
        if (i == j || i == j-1 || i == j-3 || i == j-4) begin
          if (2 * ((t - 7*rl[i]) < 0 ? 7*rl[i] - t : t - 7*rl[i]) >= t) ok = 0;
        end
      end
      j2 = j - 2;
      if (2 * ((3*t - 7*rl[j2]) < 0 ? 7*rl[j2] - 3*t : 3*t - 7*rl[j2]) >= 3*t) ok = 0;
      if (ok) begin
        e = rs[j] + rl[j];
        exp_hit[e+1] = 1;
        exp_c[e+1]   = rs[j2] + rl[j2] / 2;
        exp_w[e+1]   = t % 512;
      end
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] pat, input int repulse_at, input int reset_at);
    int cnt = 0;
    buildModel(pat);
    seen_hits = 0;
    busy_cycles = 0;
    pattern_in = pat;
    pattern_valid = 1'b1;
    @(posedge clk_in); #1;
    pattern_valid = 1'b0;
    pattern_in = ~pat;
    checkOutput("busy_accept", int'(busy), 1);
    checkOutput("count_clear", int'(hit_count), 0);
    if (busy) busy_cycles++;
    for (int c = 1; c <= WIDTH + 1; c++) begin
      if (c == repulse_at) begin pattern_valid = 1'b1; pattern_in = '0; end
      if (c == reset_at) rst_in = 1'b1;
      @(posedge clk_in); #1;
      pattern_valid = 1'b0;
      if (c == reset_at) begin
        rst_in = 1'b0;
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_hit_valid", int'(hit_valid), 0);
        checkOutput("rst_scan_done", int'(scan_done), 0);
        checkOutput("rst_center", int'(hit_center), 0);
        checkOutput("rst_width", int'(hit_width), 0);
        checkOutput("rst_count", int'(hit_count), 0);
        last_center = 0;
        last_width = 0;
        return;
      end
      if (exp_hit[c] != 0) begin
        if (cnt < 15) cnt++;
        last_center = exp_c[c];
        last_width  = exp_w[c];
      end
      if (hit_valid) seen_hits++;
      if (busy) busy_cycles++;
      checkOutput("hit_valid", int'(hit_valid), exp_hit[c]);
      checkOutput("hit_center", int'(hit_center), last_center);
      checkOutput("hit_width", int'(hit_width), last_width);
      checkOutput("hit_count", int'(hit_count), cnt);
      checkOutput("busy", int'(busy), (c <= WIDTH) ? 1 : 0);
      checkOutput("scan_done", int'(scan_done), (c == WIDTH + 1) ? 1 : 0);
    end
  endtask

  function automatic logic [WIDTH-1:0] darkRange(input logic [WIDTH-1:0] p, input int lo, input int hi);
    logic [WIDTH-1:0] r = p;
    for (int k = lo; k <= hi; k++) r[k] = 1'b0;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] finderAt(input logic [WIDTH-1:0] p, input int s, input int m);
    logic [WIDTH-1:0] r = p;
    r = darkRange(r, s, s + m - 1);
    r = darkRange(r, s + 2*m, s + 5*m - 1);
    r = darkRange(r, s + 6*m, s + 7*m - 1);
    return r;
  endfunction

  task automatic randRow(output logic [WIDTH-1:0] p);
    int col = 0;
    int len, m;
    int lens [5];
    logic color;
    p = '1;
    color = 1'($urandom_range(0, 1));
    while (col < WIDTH) begin
      if (!color && $urandom_range(0, 2) == 0) begin
        m = int'($urandom_range(1, 6));
        lens = '{m, m, 3*m, m, m};
        for (int i = 0; i < 5; i++) begin
          lens[i] = lens[i] + int'($urandom_range(0, 2)) - 1;
          if (lens[i] < 1) lens[i] = 1;
          for (int k = 0; k < lens[i] && col < WIDTH; k++) begin p[col] = color; col++; end
          color = ~color;
        end
      end else begin
        len = int'($urandom_range(1, 12));
        for (int k = 0; k < len && col < WIDTH; k++) begin p[col] = color; col++; end
        color = ~color;
      end
    end
  endtask

  initial begin
    logic [WIDTH-1:0] p;
    rst_in = 1'b1;
    pattern_valid = 1'b0;
    pattern_in = '0;
    repeat (3) @(posedge clk_in);
    #1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_hit_valid", int'(hit_valid), 0);
    checkOutput("reset_scan_done", int'(scan_done), 0);
    checkOutput("reset_center", int'(hit_center), 0);
    checkOutput("reset_width", int'(hit_width), 0);
    checkOutput("reset_count", int'(hit_count), 0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    applyStimulus('1, -1, -1);
    checkOutput("light_busy_cycles", busy_cycles, 481);
    checkOutput("light_hits", seen_hits, 0);

    p = darkRange('1, 100, 103);
    p = darkRange(p, 108, 119);
    p = darkRange(p, 124, 127);
    applyStimulus(p, -1, -1);
    checkOutput("m4_hits", seen_hits, 1);
    checkOutput("m4_center", int'(hit_center), 114);
    checkOutput("m4_width", int'(hit_width), 28);
    checkOutput("m4_count", int'(hit_count), 1);

    p = darkRange('1, 100, 103);
    p = darkRange(p, 108, 111);
    p = darkRange(p, 116, 119);
    applyStimulus(p, -1, -1);
    checkOutput("equal_hits", seen_hits, 0);

    applyStimulus(finderAt('1, 452, 4), -1, -1);
    checkOutput("edge_hits", seen_hits, 1);
    checkOutput("edge_center", int'(hit_center), 466);
    checkOutput("edge_width", int'(hit_width), 28);
    checkOutput("edge_count", int'(hit_count), 1);

    applyStimulus(finderAt('1, 0, 4), -1, -1);
    checkOutput("left_center", int'(hit_center), 14);

    p = '1;
    for (int j = 0; j < 16; j++) p = finderAt(p, 10 + 28*j, 2);
    applyStimulus(p, 50, -1);
    checkOutput("sat_pulses", seen_hits, 16);
    checkOutput("sat_count", int'(hit_count), 15);

    applyStimulus(finderAt('1, 100, 4), -1, 60);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_in); #1;
      checkOutput("abort_scan_done", int'(scan_done), 0);
      checkOutput("abort_busy", int'(busy), 0);
    end
    applyStimulus('1, -1, -1);
    checkOutput("after_rst_count", int'(hit_count), 0);

    for (int r = 0; r < 8; r++) begin
      randRow(p);
      applyStimulus(p, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/finder_row_scanner.md
# finder_row_scanner

Downstream consumer of the cleaned 480-pixel row produced by the row-cleaning stage. It walks the cleaned row one pixel per clock, run-length encodes it, and flags every dark:light:dark:light:dark run group whose widths match the QR finder ratio 1:1:3:1:1. For each hit it reports the centre column and total width. Its hits feed the finder-locator logic that pairs row hits into finder-pattern candidates.

## Interface
- WIDTH, 480, pixels per row; must be ≤ 511 (9-bit indices and run lengths).
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- pattern_in  input  WIDTH  cleaned row; bit k = column k; 0 = dark, 1 = light.
- pattern_valid  input  1  one-cycle pulse; pattern_in is valid in the same cycle.
- busy  output  1  high from acceptance until the end of flush.
- hit_valid  output  1  one-cycle pulse per detected finder run group.
- hit_center  output  9  centre column of the middle dark run; valid with hit_valid.
- hit_width  output  9  total width T of the five runs; valid with hit_valid.
- scan_done  output  1  one-cycle pulse at the end of each row.
- hit_count  output  4  hits in the current or last row; saturates at 15.

## Operation
- States: IDLE, SCAN, FLUSH.
- **IDLE**
  - On pattern_valid: latch pattern_in, set index=0 and hit_count=0, raise busy, go to SCAN.
  - pattern_valid is ignored in SCAN and FLUSH. There is no queueing.
- **SCAN** (one pixel per cycle)
  - Pixel 0 opens the first run with length 1.
  - For pixel k>0:
    - If it has the same colour as pixel k-1, increment the current run length.
    - Otherwise, push the closed run (colour, length) into a 5-deep history n0 (newest) .. n4 (oldest), evaluate, and start a new run of length 1.
  - After pixel WIDTH-1 is processed, go to FLUSH.
- **FLUSH**
  - Push the final run, with its end e=WIDTH, and evaluate.
  - Pulse scan_done, drop busy, go to IDLE.
- **Evaluation** (only after a push, only when the history holds 5 runs and n0 is dark)
  - Runs alternate by construction, so n0 dark implies the pattern D,L,D,L,D.
  - T = n0+n1+n2+n3+n4, computed at 12-bit internal width.
  - Hit condition: T ≥ 7, AND 2·|T − 7·ni| < T for i ∈ {0,1,3,4}, AND 2·|3T − 7·n2| < 3T. All comparisons are signed, with no division.
  - e = index of the first pixel of the new run (WIDTH at flush).
  - hit_center = e − n0 − n1 − n2 + (n2 >> 1).
  - hit_width = T[8:0].
  - On a hit: increment hit_count, saturating at 15.
- Runs truncated by either row edge are evaluated with their truncated lengths.
- hit_center and hit_width hold their values between hits.
- **Reset**
  - All outputs go to 0: busy, hit_valid, scan_done, hit_center, hit_width, hit_count.
  - State returns to IDLE and the run history is cleared.
  - A reset mid-scan abandons the row with no scan_done.

## Timing
- E0 = the edge that samples pattern_valid high.
- Pixel k is consumed at edge E0+1+k. FLUSH executes at edge E0+WIDTH+1.
- Hits are registered at the consuming edge. hit_valid is high for exactly the cycle after the edge where the closing transition pixel (or the flush) is consumed.
- scan_done and busy=0 take effect after edge E0+WIDTH+1.
- A flush hit coincides with scan_done, and hit_count already includes it.
- The earliest next acceptance is edge E0+WIDTH+2, giving WIDTH+2 cycles per row.
- At most one hit per cycle.

## Test plan
- **All-light row** (all ones) → no hit_valid; scan_done one cycle after E0+481; hit_count=0; busy high for 481 cycles.
- **Module-4 finder, mid-row.** Dark 100–103, light 104–107, dark 108–119, light 120–123, dark 124–127, rest light.
  - Required: one hit_valid after edge E0+129, with hit_center=114, hit_width=28.
  - Required: hit_count=1.
- **Equal runs rejected.** Five runs of 4 (dark at 100–103, 108–111, 116–119; light between) → no hit (center test 64 ≮ 60).
- **Right-edge finder.** Dark 452–455, light 456–459, dark 460–471, light 472–475, dark 476–479.
  - Required: hit_valid in the same cycle as scan_done, with hit_center=466, hit_width=28, hit_count=1.
- **Saturation and busy-ignore.**
  - Stimulus: 16 module-2 finders (width 14, spaced 28 apart); pattern_valid re-pulsed at E0+50.
  - Required: 16 hit_valid pulses and hit_count=15.
  - Required: the second pulse is ignored, with no restart and scan_done at the normal time.
- **Reset mid-scan.** Assert rst_in at E0+60, then pulse pattern_valid with an all-light row.
  - Required: all outputs 0 after reset, no scan_done for the aborted row, and the new row completes normally with hit_count=0.
